plic_priority_scan: RTL and testbench

//  Sequential successor to the PLIC target's combinational priority tree. Finds the

---
 rtl/plic_priority_scan.sv | 160 ++++++++++++++++
 tb/tb_plic_priority_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_priority_scan.sv
// Sequential PLIC priority scan: finds the highest-priority pending source, LANES sources per clock.
// Optional PLIC_SCAN_RESTART_EN: a start_i during a scan restarts it instead of being ignored.
module plic_priority_scan #(
  parameter int SOURCES       = 16,
  parameter int PRIORITIES    = 7,
  parameter int LANES         = 4,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]  priority_i,
  input  logic [PRIORITY_BITS-1:0]               threshold_i,
  output logic                                   busy_o,
  output logic                                   valid_o,
  output logic [PRIORITY_BITS-1:0]               priority_o,
  output logic [SOURCES_BITS-1:0]                id_o,
  output logic                                   ireq_o
);

  localparam int NBEATS    = (SOURCES + LANES - 1) / LANES;
  localparam int BEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PADDED    = NBEATS * LANES;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                                 state_q, state_d;
  logic [BEAT_BITS-1:0]                   beat_q, beat_d;
  logic [SOURCES-1:0][PRIORITY_BITS-1:0]  snap_q, snap_d;
  logic [PRIORITY_BITS-1:0]               thr_q, thr_d;
  logic [PRIORITY_BITS-1:0]               max_prio_q, max_prio_d;
  logic [SOURCES_BITS-1:0]                max_id_q, max_id_d;
  logic                                   busy_q, busy_d;
  logic                                   valid_q, valid_d;
  logic [PRIORITY_BITS-1:0]               prio_q, prio_d;
  logic [SOURCES_BITS-1:0]                id_q, id_d;
  logic                                   ireq_q, ireq_d;

  logic [NBEATS-1:0][LANES-1:0][PRIORITY_BITS-1:0] rows;
  logic [LANES-1:0][PRIORITY_BITS-1:0]             lane_prio;
  logic [PRIORITY_BITS-1:0]                        scan_prio;
  logic [SOURCES_BITS-1:0]                         scan_id;
  logic                                            start_ok;

  // Snapshot laid out as beats of LANES entries; slots past the last source read as priority 0.
  generate
    for (genvar gi = 0; gi < PADDED; gi++) begin : g_pad
      if (gi < SOURCES) begin : g_src
        assign rows[gi / LANES][gi % LANES] = snap_q[gi];
      end else begin : g_zero
        assign rows[gi / LANES][gi % LANES] = '0;
      end
    end
  endgenerate

  assign lane_prio = rows[beat_q];

  // Lanes visited in ascending ID with a strict compare, so ties keep the lowest ID
  // and a priority-0 source can never displace the cleared running max.
  always_comb begin
    scan_prio = max_prio_q;
    scan_id   = max_id_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_prio[l] > scan_prio) begin
        scan_prio = lane_prio[l];
        scan_id   = SOURCES_BITS'(int'(beat_q) * LANES + l + 1);
      end
    end
  end

`ifdef PLIC_SCAN_RESTART_EN
  assign start_ok = start_i;
`else
  assign start_ok = start_i && (state_q != SCAN);
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    snap_d     = snap_q;
    thr_d      = thr_q;
    max_prio_d = max_prio_q;
    max_id_d   = max_id_q;
    valid_d    = 1'b0;
    prio_d     = prio_q;
    id_d       = id_q;
    ireq_d     = ireq_q;

    case (state_q)
      IDLE: ;
      SCAN: begin
        max_prio_d = scan_prio;
        max_id_d   = scan_id;
        beat_d     = beat_q + 1'b1;
        if (beat_q == BEAT_BITS'(NBEATS - 1)) begin
          state_d = DONE;
          beat_d  = '0;
          valid_d = 1'b1;
          prio_d  = scan_prio;
          id_d    = scan_id;
          ireq_d  = (scan_prio > thr_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An accepted start overrides everything, including a result that would land this cycle.
    if (start_ok) begin
      state_d    = SCAN;
      beat_d     = '0;
      snap_d     = priority_i;
      thr_d      = threshold_i;
      max_prio_d = '0;
      max_id_d   = '0;
      valid_d    = 1'b0;
      prio_d     = prio_q;
      id_d       = id_q;
      ireq_d     = ireq_q;
    end

    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      snap_q     <= '0;
      thr_q      <= '0;
      max_prio_q <= '0;
      max_id_q   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      prio_q     <= '0;
      id_q       <= '0;
      ireq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      snap_q     <= snap_d;
      thr_q      <= thr_d;
      max_prio_q <= max_prio_d;
      max_id_q   <= max_id_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      ireq_q     <= ireq_d;
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign priority_o = prio_q;
  assign id_o       = id_q;
  assign ireq_o     = ireq_q;

endmodule

// File: tb/tb_plic_priority_scan.sv
// Scoreboard bench for plic_priority_scan: 16-source/4-lane instance with random stimulus plus a
// 5-source instance for the partial last beat; honours PLIC_SCAN_RESTART_EN if defined.
module tb_plic_priority_scan;

  localparam int NS  = 16;
  localparam int NB  = 4;
  localparam int PB  = 3;
  localparam int SB  = 5;
  localparam int S2  = 5;
  localparam int NB2 = 2;
  localparam int SB2 = 3;
`ifdef PLIC_SCAN_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  typedef int arr_t [16];
  typedef struct {
    int prio;
    int id;
    int ireq;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                     rst_i = 1'b1;
  logic                     start_i = 1'b0;
  logic [NS-1:0][PB-1:0]    pri = '0;
  logic [PB-1:0]            thr = '0;
  logic                     busy, valid, ireq;
  logic [PB-1:0]            prio_o;
  logic [SB-1:0]            id_o;

  logic                     s_rst = 1'b1;
  logic                     s_start = 1'b0;
  logic [S2-1:0][PB-1:0]    s_pri = '0;
  logic [PB-1:0]            s_thr = '0;
  logic                     s_busy, s_valid, s_ireq;
  logic [PB-1:0]            s_prio;
  logic [SB2-1:0]           s_id;

  plic_priority_scan #(.SOURCES(NS), .PRIORITIES(7), .LANES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .priority_i(pri), .threshold_i(thr),
    .busy_o(busy), .valid_o(valid), .priority_o(prio_o), .id_o(id_o), .ireq_o(ireq)
  );

  plic_priority_scan #(.SOURCES(S2), .PRIORITIES(7), .LANES(4)) dut_small (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .priority_i(s_pri), .threshold_i(s_thr),
    .busy_o(s_busy), .valid_o(s_valid), .priority_o(s_prio), .id_o(s_id), .ireq_o(s_ireq)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t sb2[$];
  bit   busy_exp [8192];
  int   scan_c0 = -1000;
  bit   s_done = 1'b0;

  // Reference: highest priority wins, first (lowest) index on ties, priority 0 never wins.
  function automatic exp_t ref_scan(input int n, input arr_t pr, input int th, input int c);
    exp_t e;
    e.prio = 0;
    e.id   = 0;
    for (int i = 0; i < n; i++) begin
      if (pr[i] > e.prio) begin
        e.prio = pr[i];
        e.id   = i + 1;
      end
    end
    e.ireq = (e.prio > th) ? 1 : 0;
    e.cyc  = c;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input bit st, input bit rs, input arr_t pr, input int th);
    int n;
    bit inscan;
    exp_t e;
    @(posedge clk);
    #1;
    n = cyc;
    inscan = (n > scan_c0) && (n <= scan_c0 + NB);
    if (n < 8192) busy_exp[n] = inscan;
    rst_i   = rs;
    start_i = st;
    thr     = PB'(th);
    for (int i = 0; i < NS; i++) pri[i] = PB'(pr[i]);
    if (rs) begin
      if (sb.size() > 0 && sb[$].cyc > n) void'(sb.pop_back());
      scan_c0 = -1000;
    end else if (st && (!inscan || RESTART)) begin
      if (sb.size() > 0 && sb[$].cyc > n) void'(sb.pop_back());
      e = ref_scan(NS, pr, th, n + NB + 1);
      sb.push_back(e);
      scan_c0 = n;
    end
  endtask

  task automatic drive2(input bit st, input bit rs, input int p4, input int th);
    int n;
    arr_t pr;
    @(posedge clk);
    #1;
    n = cyc;
    foreach (pr[i]) pr[i] = 0;
    pr[4]   = p4;
    s_rst   = rs;
    s_start = st;
    s_thr   = PB'(th);
    s_pri   = '0;
    s_pri[4] = PB'(p4);
    if (rs) begin
      if (sb2.size() > 0 && sb2[$].cyc > n) void'(sb2.pop_back());
    end else if (st) begin
      sb2.push_back(ref_scan(S2, pr, th, n + NB2 + 1));
    end
  endtask

  exp_t held;
  bit   prev_rst = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      held.prio = 0;
      held.id   = 0;
      held.ireq = 0;
    end
    if (valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid_o=1 id=%0d, required no result (cycle %0d)", id_o, cyc);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("result_id", int'(id_o), e.id);
        check("result_priority", int'(prio_o), e.prio);
        check("result_ireq", int'(ireq), e.ireq);
        $display("[TB] cycle %0d result id=%0d prio=%0d ireq=%0d", cyc, id_o, prio_o, ireq);
        held = e;
      end
    end
    check("hold_id", int'(id_o), held.id);
    check("hold_priority", int'(prio_o), held.prio);
    check("hold_ireq", int'(ireq), held.ireq);
    check("busy", int'(busy), (cyc < 8192) ? int'(busy_exp[cyc]) : 0);
    prev_rst = rst_i;
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_valid) begin
      if (sb2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL small_unexpected_valid: got valid_o=1 id=%0d, required no result (cycle %0d)", s_id, cyc);
      end else begin
        e = sb2.pop_front();
        check("small_valid_cycle", cyc, e.cyc);
        check("small_id", int'(s_id), e.id);
        check("small_priority", int'(s_prio), e.prio);
        check("small_ireq", int'(s_ireq), e.ireq);
        $display("[TB] cycle %0d small result id=%0d prio=%0d ireq=%0d", cyc, s_id, s_prio, s_ireq);
      end
    end
  end

  initial begin
    repeat (2) drive2(1'b0, 1'b1, 0, 0);
    drive2(1'b0, 1'b0, 0, 0);
    drive2(1'b1, 1'b0, 2, 1);
    repeat (5) drive2(1'b0, 1'b0, 2, 1);
    drive2(1'b1, 1'b0, 2, 0);
    drive2(1'b0, 1'b1, 2, 0);
    repeat (5) drive2(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("small_reset_id", int'(s_id), 0);
    check("small_reset_priority", int'(s_prio), 0);
    check("small_reset_busy", int'(s_busy), 0);
    s_done = 1'b1;
  end

  initial begin
    arr_t z, p, q;
    foreach (z[i]) z[i] = 0;

    repeat (2) drive(1'b0, 1'b1, z, 0);
    repeat (2) drive(1'b0, 1'b0, z, 0);

    p = z; p[5] = 3; p[12] = 6;
    drive(1'b1, 1'b0, p, 2);
    repeat (6) drive(1'b0, 1'b0, z, 0);

    p = z; p[2] = 5; p[9] = 5;
    drive(1'b1, 1'b0, p, 5);
    repeat (6) drive(1'b0, 1'b0, z, 0);
    drive(1'b1, 1'b0, z, 0);
    repeat (6) drive(1'b0, 1'b0, z, 0);

    p = z; p[0] = 1;
    drive(1'b1, 1'b0, p, 0);
    p[7] = 7;
    repeat (4) drive(1'b0, 1'b0, p, 0);
    drive(1'b1, 1'b0, p, 0);
    repeat (6) drive(1'b0, 1'b0, z, 0);

    p = z; p[3] = 4;
    q = z; q[10] = 6;
    drive(1'b1, 1'b0, p, 1);
    drive(1'b0, 1'b0, p, 1);
    drive(1'b1, 1'b0, q, 1);
    repeat (8) drive(1'b0, 1'b0, z, 0);

    drive(1'b1, 1'b0, q, 0);
    drive(1'b0, 1'b0, z, 0);
    drive(1'b0, 1'b1, z, 0);
    repeat (6) drive(1'b0, 1'b0, z, 0);

    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NS; i++) p[i] = ($urandom % 2 == 0) ? int'($urandom % 8) : 0;
      drive(($urandom % 4) == 0, ($urandom % 100) == 0, p, int'($urandom % 8));
    end
    repeat (10) drive(1'b0, 1'b0, z, 0);

    for (int k = 0; k < 200 && !s_done; k++) @(posedge clk);
    check("small_sequence_done", int'(s_done), 1);
    check("scoreboard_drained", sb.size(), 0);
    check("small_scoreboard_drained", sb2.size(), 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
